// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline sequencer for the 5-stage core (IF/ID/EX/MA/WB). Sits beside the
// hazard/forwarding unit. It turns four inputs into per-stage register enables
// and bubble injects for the rest of the core:
//   - the unrecoverable data hazard flag
//   - EX-stage redirects
//   - fetch readiness
//   - data-memory busy
// It also keeps a saturating stall-cycle counter and a sticky data-memory
// timeout flag.
//
// Parameters
//   INIT_CYC  cycles spent flushing the pipeline after reset (>=1)
//   MEM_TOUT  consecutive MEMW busy cycles before o_mem_tout sets; 0 disables
//   CNT_W     stall counter width
//
// Ports
//   i_clk          core clock, single domain
//   i_rst          synchronous active-high reset
//   i_hz_data      ID instruction must wait on an unrecoverable data hazard
//   i_br_taken     EX-stage branch/jump taken (fetch redirect)
//   i_ic_rdy       fetch word valid this cycle
//   i_dc_busy      MA-stage data access not yet complete
//   o_ce_if..o_ce_wb  stage register enables
//   o_bub_id       load NOP into ID instead of the IF output
//   o_bub_ex       load NOP into EX instead of the ID output
//   o_redir_pend   redirect target must be held by fetch
//   o_stall_cnt    saturating count of non-INIT cycles with o_ce_if=0
//   o_mem_tout     sticky data-memory timeout
//
// State | meaning
// ------+---------------------------------------------------------------
// INIT  | flushing bubbles through ID..WB for INIT_CYC cycles after reset
// RUN   | normal issue; priority busy > branch > hazard > fetch miss
// MEMW  | waiting on the data memory; whole pipe frozen, timeout counting
// REDIR | redirect accepted by EX, waiting for fetch to deliver the target
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int unsigned INIT_CYC = 3,
    parameter int unsigned MEM_TOUT = 1024,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_hz_data,
    input  logic             i_br_taken,
    input  logic             i_ic_rdy,
    input  logic             i_dc_busy,
    output logic             o_ce_if,
    output logic             o_ce_id,
    output logic             o_ce_ex,
    output logic             o_ce_ma,
    output logic             o_ce_wb,
    output logic             o_bub_id,
    output logic             o_bub_ex,
    output logic             o_redir_pend,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic             o_mem_tout
);

    // Init counter loads INIT_CYC-1 and leaves INIT on the cycle it reads 0.
    localparam int unsigned INIT_LD  = (INIT_CYC == 0) ? 0 : INIT_CYC - 1;
    localparam int unsigned INIT_W   = (INIT_LD < 1) ? 1 : $clog2(INIT_LD + 1);
    localparam logic [INIT_W-1:0] INIT_LD_V = INIT_W'(INIT_LD);

    // Wait counter never needs to go past MEM_TOUT-1, where the flag sets.
    localparam int unsigned WAIT_LIM = (MEM_TOUT == 0) ? 0 : MEM_TOUT - 1;
    localparam int unsigned WAIT_W   = (WAIT_LIM < 1) ? 1 : $clog2(WAIT_LIM + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIM);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_MEMW  = 2'd2,
        ST_REDIR = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [INIT_W-1:0]  init_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   stall_cnt;
    logic               mem_tout;

    logic               ce_if;
    logic               ce_id;
    logic               ce_ex;
    logic               ce_back;
    logic               bub_id;
    logic               bub_ex;
    logic               redir_pend;

    // Stage enables and bubbles. MA and WB share one enable so they can
    // never disagree.
    always_comb begin
        ce_if      = 1'b0;
        ce_id      = 1'b0;
        ce_ex      = 1'b0;
        ce_back    = 1'b0;
        bub_id     = 1'b0;
        bub_ex     = 1'b0;
        redir_pend = 1'b0;
        state_nxt  = state;

        case (state)
            ST_INIT: begin
                ce_id   = 1'b1;
                ce_ex   = 1'b1;
                ce_back = 1'b1;
                bub_id  = 1'b1;
                bub_ex  = 1'b1;
                if (init_cnt == '0) begin
                    state_nxt = ST_RUN;
                end
            end

            // MEMW with busy released behaves exactly like RUN, and RUN with
            // busy behaves like MEMW, so both share one decode.
            ST_RUN, ST_MEMW: begin
                if (i_dc_busy) begin
                    state_nxt = ST_MEMW;
                end else if (i_br_taken) begin
                    ce_if     = 1'b1;
                    ce_id     = 1'b1;
                    ce_ex     = 1'b1;
                    ce_back   = 1'b1;
                    bub_id    = 1'b1;
                    bub_ex    = 1'b1;
                    state_nxt = i_ic_rdy ? ST_RUN : ST_REDIR;
                end else if (i_hz_data) begin
                    ce_ex     = 1'b1;
                    ce_back   = 1'b1;
                    bub_ex    = 1'b1;
                    state_nxt = ST_RUN;
                end else if (!i_ic_rdy) begin
                    ce_id     = 1'b1;
                    ce_ex     = 1'b1;
                    ce_back   = 1'b1;
                    bub_id    = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    ce_if     = 1'b1;
                    ce_id     = 1'b1;
                    ce_ex     = 1'b1;
                    ce_back   = 1'b1;
                    state_nxt = ST_RUN;
                end
            end

            // ID/EX only hold bubbles here, so branch and hazard are ignored.
            // A busy memory freezes the pipe but does not start timeout counting.
            ST_REDIR: begin
                redir_pend = 1'b1;
                if (i_dc_busy) begin
                    state_nxt = ST_REDIR;
                end else if (!i_ic_rdy) begin
                    ce_id   = 1'b1;
                    ce_ex   = 1'b1;
                    ce_back = 1'b1;
                    bub_id  = 1'b1;
                end else begin
                    ce_if     = 1'b1;
                    ce_id     = 1'b1;
                    ce_ex     = 1'b1;
                    ce_back   = 1'b1;
                    state_nxt = ST_RUN;
                end
            end

            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_INIT;
            init_cnt  <= INIT_LD_V;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            mem_tout  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == ST_INIT && init_cnt != '0) begin
                init_cnt <= init_cnt - INIT_W'(1);
            end

            if (state != ST_INIT && !ce_if && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end

            // The flag sets on the MEMW busy cycle that finds the counter
            // already at MEM_TOUT-1, i.e. after the MEM_TOUT-th MEMW cycle.
            if (state == ST_MEMW && i_dc_busy) begin
                if (wait_cnt != WAIT_MAX) begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                if (MEM_TOUT != 0 && wait_cnt == WAIT_MAX) begin
                    mem_tout <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign o_ce_if      = ce_if;
    assign o_ce_id      = ce_id;
    assign o_ce_ex      = ce_ex;
    assign o_ce_ma      = ce_back;
    assign o_ce_wb      = ce_back;
    assign o_bub_id     = bub_id;
    assign o_bub_ex     = bub_ex;
    assign o_redir_pend = redir_pend;
    assign o_stall_cnt  = stall_cnt;
    assign o_mem_tout   = mem_tout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl. A behavioural model tracks three things:
//   - remaining flush cycles
//   - whether a redirect is outstanding
//   - the length of the current data-memory busy run
// The model derives the expected enables, bubbles, stall count and timeout
// from those quantities. Directed scenarios add explicit spot values, and a
// random phase exercises everything against the model.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int INIT_CYC  = 3;
    localparam int MEM_TOUT  = 8;
    localparam int CNT_W     = 6;
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic hz = 1'b0;
    logic br = 1'b0;
    logic ic = 1'b1;
    logic busy = 1'b0;

    logic             ce_if, ce_id, ce_ex, ce_ma, ce_wb;
    logic             bub_id, bub_ex, redir_pend, mem_tout;
    logic [CNT_W-1:0] stall_cnt;

    pipe_ctrl #(
        .INIT_CYC (INIT_CYC),
        .MEM_TOUT (MEM_TOUT),
        .CNT_W    (CNT_W)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_hz_data    (hz),
        .i_br_taken   (br),
        .i_ic_rdy     (ic),
        .i_dc_busy    (busy),
        .o_ce_if      (ce_if),
        .o_ce_id      (ce_id),
        .o_ce_ex      (ce_ex),
        .o_ce_ma      (ce_ma),
        .o_ce_wb      (ce_wb),
        .o_bub_id     (bub_id),
        .o_bub_ex     (bub_ex),
        .o_redir_pend (redir_pend),
        .o_stall_cnt  (stall_cnt),
        .o_mem_tout   (mem_tout)
    );

    int checks   = 0;
    int failures = 0;

    // Model state.
    int m_init_left = 0;
    bit m_redir     = 1'b0;
    int m_busy_run  = 0;
    int m_stall     = 0;
    bit m_tout      = 1'b0;

    logic [14:0] exp_vec;
    wire  [14:0] dut_vec = {ce_if, ce_id, ce_ex, ce_ma, ce_wb,
                            bub_id, bub_ex, redir_pend, mem_tout, stall_cnt};

    task automatic predict();
        logic [4:0] ce;
        logic       bi, be, rp;
        ce = 5'b00000;
        bi = 1'b0;
        be = 1'b0;
        rp = 1'b0;
        if (m_init_left > 0) begin
            ce = 5'b01111;
            bi = 1'b1;
            be = 1'b1;
        end else if (m_redir) begin
            rp = 1'b1;
            if (busy)     ce = 5'b00000;
            else if (!ic) begin ce = 5'b01111; bi = 1'b1; end
            else          ce = 5'b11111;
        end else begin
            if (busy)     ce = 5'b00000;
            else if (br)  begin ce = 5'b11111; bi = 1'b1; be = 1'b1; end
            else if (hz)  begin ce = 5'b00111; be = 1'b1; end
            else if (!ic) begin ce = 5'b01111; bi = 1'b1; end
            else          ce = 5'b11111;
        end
        exp_vec = {ce, bi, be, rp, m_tout, 6'(m_stall)};
    endtask

    // Drive inputs just after the falling edge, then sample 1 ns later.
    task automatic apply(input logic r, input logic h, input logic b,
                         input logic c, input logic d);
        @(negedge clk);
        rst  = r;
        hz   = h;
        br   = b;
        ic   = c;
        busy = d;
        #1;
        predict();
    endtask

    // Advance the model by the rising edge that is about to happen.
    task automatic advance();
        if (rst) begin
            m_init_left = INIT_CYC;
            m_redir     = 1'b0;
            m_busy_run  = 0;
            m_stall     = 0;
            m_tout      = 1'b0;
        end else if (m_init_left > 0) begin
            m_init_left--;
        end else begin
            if (!exp_vec[14] && m_stall < STALL_MAX) m_stall++;
            if (m_redir) begin
                if (!busy && ic) m_redir = 1'b0;
                m_busy_run = 0;
            end else if (busy) begin
                m_busy_run++;
                // First busy cycle is still in RUN; the flag follows the
                // MEM_TOUT-th cycle spent waiting after that.
                if (MEM_TOUT != 0 && m_busy_run >= MEM_TOUT + 1) m_tout = 1'b1;
            end else begin
                m_busy_run = 0;
                if (br && !ic) m_redir = 1'b1;
            end
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        apply(1, 0, 0, 1, 0);
        advance();
        apply(1, 0, 0, 1, 0);
        checks++;
        if (dut_vec !== exp_vec) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", dut_vec, exp_vec);
        end
        advance();
        for (int i = 0; i < INIT_CYC; i++) begin
            apply(0, 0, 0, 1, 0);
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++;
                $display("FAIL reset_init cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec);
            end
            checks++;
            if ({ce_if, ce_id, bub_id, bub_ex, redir_pend} !== 5'b01110) begin
                failures++;
                $display("FAIL reset_init_pins cyc=%0d got=%b exp=01110", i,
                         {ce_if, ce_id, bub_id, bub_ex, redir_pend});
            end
            advance();
        end
        apply(0, 0, 0, 1, 0);
        checks++;
        if ({ce_if, ce_id, ce_ex, ce_ma, ce_wb, bub_id, bub_ex} !== 7'b1111100
            || stall_cnt !== 6'd0 || mem_tout !== 1'b0) begin
            failures++;
            $display("FAIL reset_run got=%h exp=%h", dut_vec, 15'h7c00);
        end
        advance();
    endtask

    task automatic test_hazard();
        int s0;
        s0 = m_stall;
        for (int i = 0; i < 2; i++) begin
            apply(0, 1, 0, 1, 0);
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++;
                $display("FAIL hazard cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec);
            end
            checks++;
            if ({ce_if, ce_id, ce_ex, bub_ex} !== 4'b0011) begin
                failures++;
                $display("FAIL hazard_pins cyc=%0d got=%b exp=0011", i,
                         {ce_if, ce_id, ce_ex, bub_ex});
            end
            advance();
        end
        apply(0, 0, 0, 1, 0);
        checks++;
        if (stall_cnt !== 6'(s0 + 2)) begin
            failures++;
            $display("FAIL hazard_stall got=%0d exp=%0d", stall_cnt, s0 + 2);
        end
        advance();
    endtask

    task automatic test_redirect();
        int s0;
        s0 = m_stall;
        apply(0, 1, 1, 0, 0);
        checks++;
        if ({ce_if, bub_id, bub_ex, redir_pend} !== 4'b1110 || dut_vec !== exp_vec) begin
            failures++;
            $display("FAIL redir_squash got=%h exp=%h", dut_vec, exp_vec);
        end
        advance();
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 0, 0, 0);
            checks++;
            if ({ce_if, ce_id, bub_id, redir_pend} !== 4'b0111 || dut_vec !== exp_vec) begin
                failures++;
                $display("FAIL redir_wait cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec);
            end
            advance();
        end
        apply(0, 0, 0, 1, 0);
        checks++;
        if ({ce_if, ce_id, ce_ex, ce_ma, ce_wb, bub_id, redir_pend} !== 7'b1111101) begin
            failures++;
            $display("FAIL redir_accept got=%h exp=%h", dut_vec, exp_vec);
        end
        advance();
        apply(0, 0, 0, 1, 0);
        checks++;
        if (redir_pend !== 1'b0 || stall_cnt !== 6'(s0 + 2) || dut_vec !== exp_vec) begin
            failures++;
            $display("FAIL redir_done got=%h exp=%h stall_exp=%0d", dut_vec, exp_vec, s0 + 2);
        end
        advance();
    endtask

    task automatic test_mem_hold();
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, 1, 1, 1);
            checks++;
            if ({ce_if, ce_id, ce_ex, ce_ma, ce_wb, bub_id, bub_ex} !== 7'b0 ||
                dut_vec !== exp_vec) begin
                failures++;
                $display("FAIL memhold cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec);
            end
            advance();
        end
        apply(0, 1, 1, 1, 0);
        checks++;
        if ({ce_if, ce_ex, bub_id, bub_ex} !== 4'b1111 || dut_vec !== exp_vec) begin
            failures++;
            $display("FAIL memhold_release got=%h exp=%h", dut_vec, exp_vec);
        end
        advance();
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 20; i++) begin
            apply(0, 0, 0, 1, 1);
            checks++;
            if (mem_tout !== (i >= MEM_TOUT + 1) || dut_vec !== exp_vec) begin
                failures++;
                $display("FAIL timeout cyc=%0d tout=%b got=%h exp=%h", i, mem_tout,
                         dut_vec, exp_vec);
            end
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 1, 0);
            checks++;
            if (mem_tout !== 1'b1 || dut_vec !== exp_vec) begin
                failures++;
                $display("FAIL timeout_sticky cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_rst_redir();
        apply(0, 0, 1, 0, 0);
        advance();
        apply(0, 0, 0, 0, 0);
        checks++;
        if (redir_pend !== 1'b1 || mem_tout !== 1'b1 || dut_vec !== exp_vec) begin
            failures++;
            $display("FAIL rstredir_pre got=%h exp=%h", dut_vec, exp_vec);
        end
        advance();
        apply(1, 0, 0, 0, 0);
        advance();
        apply(0, 0, 0, 1, 0);
        checks++;
        if ({ce_if, bub_id, bub_ex, redir_pend, mem_tout} !== 5'b01100 ||
            stall_cnt !== 6'd0 || dut_vec !== exp_vec) begin
            failures++;
            $display("FAIL rstredir_post got=%h exp=%h", dut_vec, exp_vec);
        end
        advance();
        for (int i = 0; i < INIT_CYC; i++) begin
            apply(0, 0, 0, 1, 0);
            advance();
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 75; i++) begin
            apply(0, 0, 0, 1, 1);
            advance();
        end
        apply(0, 0, 0, 1, 0);
        checks++;
        if (stall_cnt !== 6'(STALL_MAX) || dut_vec !== exp_vec) begin
            failures++;
            $display("FAIL saturate got=%h exp=%h", dut_vec, exp_vec);
        end
        advance();
    endtask

    task automatic test_random();
        logic r, h, b, c, d;
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 59) == 0);
            h = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 5) == 0);
            c = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 4) == 0) || (i % 97 > 80);
            apply(r, h, b, c, d);
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec);
            end
            checks++;
            if ((bub_id && !ce_id) || (bub_ex && !ce_ex) || (ce_ma !== ce_wb)) begin
                failures++;
                $display("FAIL random_invariant cyc=%0d got=%b exp=consistent", i,
                         {ce_id, ce_ex, ce_ma, ce_wb, bub_id, bub_ex});
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_hazard();
        test_redirect();
        test_mem_hold();
        test_timeout();
        test_rst_redir();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
